// File: rtl/ibex_pkg.sv
// Shared types for the instruction-bus arbiter: host identifiers and arbiter FSM states.
package ibex_pkg;

  typedef logic host_id_t;

  localparam host_id_t HostPfb = 1'b0;
  localparam host_id_t HostSec = 1'b1;

  typedef enum logic {StIdle, StHold} arb_state_e;

endpackage

// File: rtl/ibex_instr_arb_id_fifo.sv
// In-order FIFO of granted host IDs; the head tells which host owns the next bus response.
module ibex_instr_arb_id_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter bit          ResetAll = 1'b0
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  host_id_t id_i,
  input  logic     pop_i,
  output host_id_t id_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  host_id_t        mem_q [Depth];
  logic            push_en, pop_en;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  // Guards keep the counter from wrapping even if a caller misbehaves.
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign id_o    = mem_q[rptr_q];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wptr_q <= ptr_inc(wptr_q);
      if (pop_en)  rptr_q <= ptr_inc(rptr_q);
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  if (ResetAll) begin : gen_mem_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mem_q <= '{default: HostPfb};
      end else if (push_en) begin
        mem_q[wptr_q] <= id_i;
      end
    end
  end else begin : gen_mem_norst
    always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wptr_q] <= id_i;
    end
  end

endmodule

// File: rtl/ibex_instr_bus_arb.sv
// Round-robin arbiter sharing one instruction bus between the prefetch buffer (h0) and a
// secondary fetcher (h1), with in-order response routing.
module ibex_instr_bus_arb
  import ibex_pkg::*;
#(
  parameter int unsigned NumOutstanding = 4,
  parameter bit          ResetAll       = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        h0_req_i,
  input  logic [31:0] h0_addr_i,
  output logic        h0_gnt_o,
  output logic        h0_rvalid_o,
  output logic [31:0] h0_rdata_o,
  output logic        h0_err_o,

  input  logic        h1_req_i,
  input  logic [31:0] h1_addr_i,
  output logic        h1_gnt_o,
  output logic        h1_rvalid_o,
  output logic [31:0] h1_rdata_o,
  output logic        h1_err_o,

  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,

  output logic        busy_o
);

  arb_state_e  state_q;
  host_id_t    last_q, sel_q, winner, sel, head_id;
  logic [31:0] addr_q, win_addr;
  logic        hold, full, empty, push, pop;

  always_comb begin
    if (h0_req_i && h1_req_i) begin
      winner = ~last_q;
    end else if (h1_req_i) begin
      winner = HostSec;
    end else begin
      winner = HostPfb;
    end
    win_addr = (winner == HostSec) ? h1_addr_i : h0_addr_i;
    hold     = (state_q == StHold);
    sel      = hold ? sel_q : winner;

    // A request stalled without grant is frozen, independent of the FIFO filling.
    instr_req_o  = hold | ((h0_req_i | h1_req_i) & ~full);
    instr_addr_o = hold ? addr_q : {win_addr[31:2], 2'b00};

    push        = instr_req_o & instr_gnt_i;
    h0_gnt_o    = push & (sel == HostPfb);
    h1_gnt_o    = push & (sel == HostSec);

    pop         = instr_rvalid_i & ~empty;
    h0_rvalid_o = pop & (head_id == HostPfb);
    h1_rvalid_o = pop & (head_id == HostSec);

    busy_o      = ~empty | instr_req_o;
  end

  assign h0_rdata_o = instr_rdata_i;
  assign h1_rdata_o = instr_rdata_i;
  assign h0_err_o   = instr_err_i;
  assign h1_err_o   = instr_err_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      last_q  <= HostSec;
      sel_q   <= HostPfb;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (instr_req_o && !instr_gnt_i) begin
            state_q <= StHold;
            sel_q   <= winner;
          end
        end
        StHold: begin
          if (instr_gnt_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (push) last_q <= sel;
    end
  end

  if (ResetAll) begin : gen_addr_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        addr_q <= '0;
      end else if (!hold) begin
        addr_q <= {win_addr[31:2], 2'b00};
      end
    end
  end else begin : gen_addr_norst
    always_ff @(posedge clk_i) begin
      if (!hold) addr_q <= {win_addr[31:2], 2'b00};
    end
  end

  ibex_instr_arb_id_fifo #(
    .Depth    (NumOutstanding),
    .ResetAll (ResetAll)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .id_i    (sel),
    .pop_i   (pop),
    .id_o    (head_id),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_ibex_instr_bus_arb.sv
// Directed bench for ibex_instr_bus_arb: arbitration order, stall hold, FIFO full/drain,
// response routing, error forwarding and mid-transaction reset.
module tb_ibex_instr_bus_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        h0_req_i = 1'b0, h1_req_i = 1'b0;
  logic [31:0] h0_addr_i = '0, h1_addr_i = '0;
  logic        h0_gnt_o, h0_rvalid_o, h0_err_o, h1_gnt_o, h1_rvalid_o, h1_err_o;
  logic [31:0] h0_rdata_o, h1_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ibex_instr_bus_arb #(
    .NumOutstanding (4),
    .ResetAll       (1'b0)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .h0_req_i       (h0_req_i),
    .h0_addr_i      (h0_addr_i),
    .h0_gnt_o       (h0_gnt_o),
    .h0_rvalid_o    (h0_rvalid_o),
    .h0_rdata_o     (h0_rdata_o),
    .h0_err_o       (h0_err_o),
    .h1_req_i       (h1_req_i),
    .h1_addr_i      (h1_addr_i),
    .h1_gnt_o       (h1_gnt_o),
    .h1_rvalid_o    (h1_rvalid_o),
    .h1_rdata_o     (h1_rdata_o),
    .h1_err_o       (h1_err_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic r1,
                       input logic [31:0] a1, input logic gnt);
    h0_req_i = r0; h0_addr_i = a0; h1_req_i = r1; h1_addr_i = a1; instr_gnt_i = gnt;
  endtask

  task automatic resp(input logic rv, input logic [31:0] d, input logic e);
    instr_rvalid_i = rv; instr_rdata_i = d; instr_err_i = e;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", instr_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_gnts", {h0_gnt_o, h1_gnt_o}, 0);
    chk("rst_rvalids", {h0_rvalid_o, h1_rvalid_o}, 0);
    #10 rst_ni = 1'b1;
    step();

    // Stray rvalid on an empty FIFO
    resp(1, 32'hDEAD_BEEF, 0); #1;
    chk("stray0_rvalids", {h0_rvalid_o, h1_rvalid_o}, 0);
    chk("stray0_busy", busy_o, 0);
    step(); resp(0, 0, 0);

    // Both hosts contend with grant every cycle: addresses alternate
    drive(1, 32'h100, 1, 32'h200, 1); #1;
    chk("rr0_addr", instr_addr_o, 32'h100);
    chk("rr0_gnt", {h0_gnt_o, h1_gnt_o}, 2'b10);
    step(); h0_addr_i = 32'h104; #1;
    chk("rr1_addr", instr_addr_o, 32'h200);
    chk("rr1_gnt", {h0_gnt_o, h1_gnt_o}, 2'b01);
    step(); h1_addr_i = 32'h204; #1;
    chk("rr2_addr", instr_addr_o, 32'h104);
    chk("rr2_gnt", {h0_gnt_o, h1_gnt_o}, 2'b10);
    step(); drive(0, 0, 0, 0, 0);
    resp(1, 32'hA0, 0); #1;
    chk("rr_rsp0", {h0_rvalid_o, h1_rvalid_o}, 2'b10);
    chk("rr_rsp0_data", h0_rdata_o, 32'hA0);
    step(); resp(1, 32'hA1, 0); #1;
    chk("rr_rsp1", {h0_rvalid_o, h1_rvalid_o}, 2'b01);
    chk("rr_rsp1_data", h1_rdata_o, 32'hA1);
    step(); resp(1, 32'hA2, 0); #1;
    chk("rr_rsp2", {h0_rvalid_o, h1_rvalid_o}, 2'b10);
    step(); resp(0, 0, 0); #1;
    chk("rr_busy", busy_o, 0);

    // h1 stalls for three cycles while h0 raises its request
    drive(0, 0, 1, 32'h80, 0); #1;
    chk("hold0_req", instr_req_o, 1);
    chk("hold0_addr", instr_addr_o, 32'h80);
    step(); drive(1, 32'h300, 1, 32'h80, 0); #1;
    chk("hold1_addr", instr_addr_o, 32'h80);
    chk("hold1_gnts", {h0_gnt_o, h1_gnt_o}, 0);
    step(); #1;
    chk("hold2_addr", instr_addr_o, 32'h80);
    chk("hold2_req", instr_req_o, 1);
    step(); instr_gnt_i = 1; #1;
    chk("hold3_addr", instr_addr_o, 32'h80);
    chk("hold3_gnts", {h0_gnt_o, h1_gnt_o}, 2'b01);
    step(); drive(0, 0, 0, 0, 0); resp(1, 32'hB0, 0); #1;
    chk("hold_rsp", {h0_rvalid_o, h1_rvalid_o}, 2'b01);
    step(); resp(0, 0, 0);

    // Fill the FIFO with h0,h1,h0,h0 then drain in order
    drive(1, 32'h13, 0, 0, 1); #1;
    chk("fill0_addr_align", instr_addr_o, 32'h10);
    chk("fill0_gnt", {h0_gnt_o, h1_gnt_o}, 2'b10);
    step(); drive(0, 0, 1, 32'h20, 1); #1;
    chk("fill1_gnt", {h0_gnt_o, h1_gnt_o}, 2'b01);
    step(); drive(1, 32'h30, 0, 0, 1); #1;
    chk("fill2_gnt", {h0_gnt_o, h1_gnt_o}, 2'b10);
    step(); drive(1, 32'h34, 0, 0, 1); #1;
    chk("fill3_gnt", {h0_gnt_o, h1_gnt_o}, 2'b10);
    step(); drive(1, 32'h38, 1, 32'h40, 1); resp(1, 32'hD0, 0); #1;
    chk("full_req", instr_req_o, 0);
    chk("full_gnts", {h0_gnt_o, h1_gnt_o}, 0);
    chk("full_busy", busy_o, 1);
    chk("drain0", {h0_rvalid_o, h1_rvalid_o}, 2'b10);
    chk("drain0_data", h0_rdata_o, 32'hD0);
    step(); drive(0, 0, 0, 0, 0); resp(1, 32'hD1, 0); #1;
    chk("drain1", {h0_rvalid_o, h1_rvalid_o}, 2'b01);
    chk("drain1_data", h1_rdata_o, 32'hD1);
    step(); resp(1, 32'hD2, 0); #1;
    chk("drain2", {h0_rvalid_o, h1_rvalid_o}, 2'b10);
    step(); resp(1, 32'hD3, 0); #1;
    chk("drain3", {h0_rvalid_o, h1_rvalid_o}, 2'b10);
    chk("drain3_data", h0_rdata_o, 32'hD3);
    step(); resp(0, 0, 0); #1;
    chk("drain_busy", busy_o, 0);

    // Simultaneous push and pop with two outstanding
    drive(0, 0, 1, 32'h50, 1);
    step(); drive(1, 32'h40, 0, 0, 1);
    step(); drive(1, 32'h44, 0, 0, 1); resp(1, 32'hC0, 0); #1;
    chk("pp_gnt", {h0_gnt_o, h1_gnt_o}, 2'b10);
    chk("pp_rsp", {h0_rvalid_o, h1_rvalid_o}, 2'b01);
    step(); drive(0, 0, 0, 0, 0); resp(1, 32'hC1, 0); #1;
    chk("pp_rsp1", {h0_rvalid_o, h1_rvalid_o}, 2'b10);
    step(); resp(1, 32'hC2, 0); #1;
    chk("pp_rsp2", {h0_rvalid_o, h1_rvalid_o}, 2'b10);
    step(); resp(1, 32'hC3, 0); #1;
    chk("pp_extra_ignored", {h0_rvalid_o, h1_rvalid_o}, 0);
    chk("pp_busy", busy_o, 0);
    step(); resp(0, 0, 0);

    // Error response on an h1 transaction
    drive(0, 0, 1, 32'h60, 1); #1;
    chk("err_gnt", {h0_gnt_o, h1_gnt_o}, 2'b01);
    step(); drive(0, 0, 0, 0, 0); resp(1, 32'hE0, 1); #1;
    chk("err_rvalids", {h0_rvalid_o, h1_rvalid_o}, 2'b01);
    chk("err_h1_err", h1_err_o, 1);
    chk("err_h0_gnt", h0_gnt_o, 0);
    step(); resp(0, 0, 0); #1;
    chk("err_after", {h0_rvalid_o, h1_rvalid_o}, 0);

    // Reset with three outstanding, then a stray response
    drive(1, 32'h70, 0, 0, 1);
    step(); drive(0, 0, 1, 32'h74, 1);
    step(); drive(1, 32'h78, 0, 0, 1);
    step(); drive(0, 0, 0, 0, 0); #1;
    chk("pre_rst_busy", busy_o, 1);
    rst_ni = 1'b0; #1;
    chk("in_rst_busy", busy_o, 0);
    step(); rst_ni = 1'b1; #1;
    resp(1, 32'hF0, 0); #1;
    chk("post_rst_rvalids", {h0_rvalid_o, h1_rvalid_o}, 0);
    chk("post_rst_busy", busy_o, 0);
    step(); resp(0, 0, 0); drive(1, 32'h90, 1, 32'hA0, 1); #1;
    chk("post_rst_gnt", {h0_gnt_o, h1_gnt_o}, 2'b10);
    chk("post_rst_addr", instr_addr_o, 32'h90);
    step(); drive(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
